// File: rtl/rot_sequencer.sv
// rot_sequencer: drives an external 8-bit left rotator, one step per clock.
// Optional macro ROT_SEQ_ZERO_SKIP_EN: bypass rotation-invariant commands.
module rot_sequencer #(
    parameter int REPS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        din,
    input  logic [2:0]        amt,
    input  logic              dir,
    input  logic [REPS_W-1:0] reps,
    output logic [7:0]        sh_in,
    output logic [2:0]        sh_amt,
    input  logic [7:0]        sh_out,
    output logic [7:0]        dout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        work_q, work_d;
    logic [2:0]        amt_q, amt_d;
    logic [REPS_W-1:0] cnt_q, cnt_d;
    logic [7:0]        dout_q, dout_d;
    logic              skip;

`ifdef ROT_SEQ_ZERO_SKIP_EN
    assign skip = (amt == 3'd0) || (din == 8'h00) || (din == 8'hFF);
`else
    assign skip = 1'b0;
`endif

    // Next-state and datapath updates; right rotation becomes left by (8-amt) mod 8.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = din;
                    amt_d  = dir ? (3'd0 - amt) : amt;
                    cnt_d  = reps;
                    if ((reps == '0) || skip) begin
                        state_d = DONE;
                        dout_d  = din;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                work_d = sh_out;
                cnt_d  = cnt_q - {{(REPS_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(REPS_W-1){1'b0}}, 1'b1}) begin
                    state_d = DONE;
                    dout_d  = sh_out;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= 8'h00;
            amt_q   <= 3'd0;
            cnt_q   <= '0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign sh_in  = work_q;
    assign sh_amt = amt_q;
    assign dout   = dout_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_rot_sequencer.sv
// tb_rot_sequencer: randomized scoreboard bench for rot_sequencer.
// Includes a behavioural model of the downstream left rotator.
module tb_rot_sequencer;

    localparam int REPS_W = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        din;
    logic [2:0]        amt;
    logic              dir;
    logic [REPS_W-1:0] reps;
    logic [7:0]        sh_in;
    logic [2:0]        sh_amt;
    logic [7:0]        sh_out;
    logic [7:0]        dout;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t sbq[$];

    rot_sequencer #(.REPS_W(REPS_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .din    (din),
        .amt    (amt),
        .dir    (dir),
        .reps   (reps),
        .sh_in  (sh_in),
        .sh_amt (sh_amt),
        .sh_out (sh_out),
        .dout   (dout),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Rotate one bit position at a time, n times.
    function automatic logic [7:0] rot(input logic [7:0] d, input int n, input logic right);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < n; i++)
            r = right ? {r[0], r[7:1]} : {r[6:0], r[7]};
        return r;
    endfunction

    // External combinational left rotator.
    always_comb sh_out = rot(sh_in, int'(sh_amt), 1'b0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit invariant(input logic [7:0] d, input logic [2:0] a);
`ifdef ROT_SEQ_ZERO_SKIP_EN
        return (a == 3'd0) || (d == 8'h00) || (d == 8'hFF);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one command from IDLE; returns 1 ns after the accepting edge.
    task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic r, input int n);
        exp_t e;
        int   lat;
        int   w;
        w = 0;
        @(negedge clk);
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
        din   = d;
        amt   = a;
        dir   = r;
        reps  = REPS_W'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = (n == 0 || invariant(d, a)) ? 0 : n;
        e.d = rot(d, (int'(a) * n) % 8, r);
        e.c = cyc + lat;
        sbq.push_back(e);
        chk("sh_in_load", 32'(sh_in), 32'(d));
        chk("sh_amt_load", 32'(sh_amt), r ? 32'((8 - int'(a)) % 8) : 32'(a));
        chk("busy_after_e0", 32'(busy), 32'd1);
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                chk("done_width", 32'(prev_done), 32'd0);
                chk("busy_in_done", 32'(busy), 32'd1);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(sbq.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("dout", 32'(dout), 32'(e.d));
                    chk("done_cycle", 32'(cyc), 32'(e.c));
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        int w;
        reset = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        amt   = 3'd0;
        dir   = 1'b0;
        reps  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sh_in", 32'(sh_in), 32'd0);
        chk("rst_sh_amt", 32'(sh_amt), 32'd0);
        reset = 1'b0;

        issue(8'h81, 3'd1, 1'b0, 1);
        issue(8'h81, 3'd3, 1'b1, 1);

        issue(8'h01, 3'd2, 1'b0, 5);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk("sh_in_step", 32'(sh_in), 32'(rot(8'h01, (2 * k) % 8, 1'b0)));
        end

        issue(8'hA5, 3'd1, 1'b0, 0);

        issue(8'h3C, 3'd1, 1'b0, 4);
        @(negedge clk);
        din   = 8'h00;
        reps  = REPS_W'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        issue(8'h5A, 3'd1, 1'b0, 9);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;

        issue(8'hFF, 3'd3, 1'b0, 9);
        issue(8'h00, 3'd5, 1'b1, 7);
        issue(8'h96, 3'd0, 1'b1, 3);

        for (int i = 0; i < 40; i++)
            issue(8'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(0, 15)));

        w = 0;
        while ((sbq.size() != 0 || busy) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
